// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings and scoreboard entry type for the core pipeline
//
// Contents:
//   RF_AW       default register-index width
//   fwd_sel_e   operand source select: FWD_RF, FWD_MEM, FWD_WB
//   npc_op_e    decoder next-PC select: NPC_PC4, NPC_RA, NPC_IMM
//   sb_entry_t  one in-flight destination {rd, we, load}
//   SB_BUBBLE   empty scoreboard entry
package riscv_pkg;

    localparam int RF_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_RA  = 2'b01,
        NPC_IMM = 2'b10
    } npc_op_e;

    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic             we;
        logic             load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{rd: '0, we: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage decode info in, pipeline sequencing controls out
//
// Signals:
//   ext_stall                       global freeze
//   id_valid, id_rs1/2, id_rf1/2    ID instruction and its source reads
//   id_rd, id_rf_we, id_load        ID destination info
//   id_branch, id_npc_op            ID-resolved control transfer info
//   pc_hold, ifid_hold              front-end holds
//   ifid_flush, idex_flush          bubble inserts
//   fwd_id1/2, fwd_ex1/2            operand forwarding selects
// Modports: master = core side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              ext_stall;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rf1;
    logic              id_rf2;
    logic [REG_AW-1:0] id_rd;
    logic              id_rf_we;
    logic              id_load;
    logic              id_branch;
    logic [1:0]        id_npc_op;
    logic              pc_hold;
    logic              ifid_hold;
    logic              ifid_flush;
    logic              idex_flush;
    logic [1:0]        fwd_id1;
    logic [1:0]        fwd_id2;
    logic [1:0]        fwd_ex1;
    logic [1:0]        fwd_ex2;

    modport master (
        output ext_stall, id_valid, id_rs1, id_rs2, id_rf1, id_rf2,
               id_rd, id_rf_we, id_load, id_branch, id_npc_op,
        input  pc_hold, ifid_hold, ifid_flush, idex_flush,
               fwd_id1, fwd_id2, fwd_ex1, fwd_ex2
    );

    modport slave (
        input  ext_stall, id_valid, id_rs1, id_rs2, id_rf1, id_rf2,
               id_rd, id_rf_we, id_load, id_branch, id_npc_op,
        output pc_hold, ifid_hold, ifid_flush, idex_flush,
               fwd_id1, fwd_id2, fwd_ex1, fwd_ex2
    );

endinterface

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - 3-entry in-flight destination scoreboard (EX, MEM, WB)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   freeze            hold every entry (global stall)
//   advance           ID instruction moves into EX; otherwise a bubble enters
//   id_entry          destination info of the ID instruction
//   ex_q, mem_q, wb_q current scoreboard contents
module hazard_sb
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      freeze,
    input  logic      advance,
    input  sb_entry_t id_entry,
    output sb_entry_t ex_q,
    output sb_entry_t mem_q,
    output sb_entry_t wb_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SB_BUBBLE;
            mem_q <= SB_BUBBLE;
            wb_q  <= SB_BUBBLE;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= advance ? id_entry : SB_BUBBLE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection, stall/flush and forwarding control for the 5-stage core
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   hz (slave)       ID decode info in; holds, flushes and forwarding selects out
//   perf_stall_cnt   hazard stall cycles (HAZ_PERF_EN only)
//   perf_flush_cnt   IF/ID flush cycles  (HAZ_PERF_EN only)
// Optional feature macro: HAZ_PERF_EN.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_AW = RF_AW,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    sb_entry_t  ex_e, mem_e, wb_e;
    sb_entry_t  id_entry;
    logic       m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
    logic       stall, advance;
    logic [1:0] fwd_ex1_d, fwd_ex2_d;
    logic [1:0] fwd_ex1_q, fwd_ex2_q;

    // x0 never produces a hazard, so a zero source index never matches.
    function automatic logic src_match(sb_entry_t s, logic valid, logic rf,
                                       logic [REG_AW-1:0] r);
        return valid && rf && (r != '0) && s.we && (s.rd == r);
    endfunction

    // A load in MEM has no data yet, so fall through to the WB copy.
    function automatic logic [1:0] id_sel(logic mm, logic mem_load, logic mw);
        if (mm && !mem_load) return FWD_MEM;
        if (mw)              return FWD_WB;
        return FWD_RF;
    endfunction

    // Looked one stage ahead: whatever is in EX now is in MEM when we reach EX.
    function automatic logic [1:0] ex_sel(logic me, logic mm);
        if (me) return FWD_MEM;
        if (mm) return FWD_WB;
        return FWD_RF;
    endfunction

    assign id_entry = '{rd: hz.id_rd, we: hz.id_rf_we, load: hz.id_load};

    hazard_sb u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze   (hz.ext_stall),
        .advance  (advance),
        .id_entry (id_entry),
        .ex_q     (ex_e),
        .mem_q    (mem_e),
        .wb_q     (wb_e)
    );

    assign m_ex1  = src_match(ex_e,  hz.id_valid, hz.id_rf1, hz.id_rs1);
    assign m_ex2  = src_match(ex_e,  hz.id_valid, hz.id_rf2, hz.id_rs2);
    assign m_mem1 = src_match(mem_e, hz.id_valid, hz.id_rf1, hz.id_rs1);
    assign m_mem2 = src_match(mem_e, hz.id_valid, hz.id_rf2, hz.id_rs2);
    assign m_wb1  = src_match(wb_e,  hz.id_valid, hz.id_rf1, hz.id_rs1);
    assign m_wb2  = src_match(wb_e,  hz.id_valid, hz.id_rf2, hz.id_rs2);

    // Branch operands are needed in ID, one stage earlier than ALU operands,
    // so they wait one extra cycle on every producer. A load in EX feeding a
    // branch stalls here twice: once via the EX rule, then via the MEM rule.
    assign stall = ((m_ex1 | m_ex2) & ex_e.load)
                 | (hz.id_branch & (m_ex1 | m_ex2))
                 | (hz.id_branch & (m_mem1 | m_mem2) & mem_e.load);

    assign advance   = hz.id_valid & ~stall;
    assign fwd_ex1_d = ex_sel(m_ex1, m_mem1);
    assign fwd_ex2_d = ex_sel(m_ex2, m_mem2);

    // Outputs are forced low while reset is asserted so no flush or hold
    // leaks out of a reset that lands in the middle of a stall.
    always_comb begin
        hz.pc_hold    = 1'b0;
        hz.ifid_hold  = 1'b0;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.fwd_id1    = FWD_RF;
        hz.fwd_id2    = FWD_RF;
        if (rst_n) begin
            hz.pc_hold    = hz.ext_stall | stall;
            hz.ifid_hold  = hz.ext_stall | stall;
            hz.idex_flush = ~hz.ext_stall & stall;
            hz.ifid_flush = ~hz.ext_stall & ~stall & hz.id_valid
                          & (hz.id_npc_op != NPC_PC4);
            hz.fwd_id1    = id_sel(m_mem1, mem_e.load, m_wb1);
            hz.fwd_id2    = id_sel(m_mem2, mem_e.load, m_wb2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_ex1_q <= FWD_RF;
            fwd_ex2_q <= FWD_RF;
        end else if (!hz.ext_stall) begin
            fwd_ex1_q <= advance ? fwd_ex1_d : FWD_RF;
            fwd_ex2_q <= advance ? fwd_ex2_d : FWD_RF;
        end
    end

    assign hz.fwd_ex1 = fwd_ex1_q;
    assign hz.fwd_ex2 = fwd_ex2_q;

    // WB results are only forwarded, never checked for load latency.
    wire wb_load_unused = wb_e.load;

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && !hz.ext_stall) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (hz.ifid_flush)          perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
        end
    end
`else
    wire cnt_w_unused = (CNT_W > 0);
`endif

endmodule
